// File: rtl/mux_stream_demux_pkg.sv
// Shared types and helpers for the mux stream demultiplexer.
// The optional idle timeout is enabled by defining MUX_STREAM_DEMUX_TIMEOUT_EN.
package mux_stream_demux_pkg;

  // Default select width; the reconstructed word is 2**SEL_W bits wide.
  localparam int SEL_W_DEF = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Word width derived from the select width.
  function automatic int word_width(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/mux_stream_demux_if.sv
// Sample-in / word-out bundle of the mux stream demultiplexer.
// slave is the demux side, master is the producer/consumer side.
interface mux_stream_demux_if
  import mux_stream_demux_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = 8
) ();

  localparam int N = word_width(SEL_W);

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             dup_err;
  logic [CNT_W-1:0] frame_cnt;
  logic             timeout;

  modport slave (
    input  in_valid, in_sel, in_bit, out_ready,
    output in_ready, out_valid, out_data, dup_err, frame_cnt, timeout
  );

  modport master (
    output in_valid, in_sel, in_bit, out_ready,
    input  in_ready, out_valid, out_data, dup_err, frame_cnt, timeout
  );

endinterface

// File: rtl/mux_stream_idle_timer.sv
// Load-clear idle counter: counts cycles while run is high and pulses
// expire combinationally on the TERM-th consecutive run cycle.
// Only instantiated when MUX_STREAM_DEMUX_TIMEOUT_EN is defined.
module mux_stream_idle_timer #(
  parameter int TERM = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int W = $clog2(TERM + 1);

  logic [W-1:0] cnt_reg;

  // Terminal pulse on the cycle the count would reach TERM.
  assign expire = run && !clr && (cnt_reg == W'(TERM - 1));

  // Counter: clear wins, self-clears on expiry, otherwise counts run cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || expire) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mux_stream_demux.sv
// Rebuilds an N-bit word from (select, bit) samples of a mux sweep.
// Each sample lands in bit position sel; once every position has been written
// the word is handed off on a valid/ready port and the block waits for it.
// Optional feature: define MUX_STREAM_DEMUX_TIMEOUT_EN to discard partial
// frames after TIMEOUT_CYC idle cycles (timeout output pulses); otherwise
// timeout is tied low and partial frames wait indefinitely.
module mux_stream_demux
  import mux_stream_demux_pkg::*;
#(
  parameter int SEL_W       = SEL_W_DEF,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input logic              clk,
  input logic              rst_n,
  mux_stream_demux_if.slave bus
);

  localparam int N = word_width(SEL_W);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t           state_reg;
  state_t           state_next;
  logic [N-1:0]     data_reg;
  logic [N-1:0]     mask_reg;
  logic [N-1:0]     sel_onehot;
  logic [N-1:0]     data_merge;
  logic [N-1:0]     mask_merge;
  logic             accept;
  logic             dup;
  logic             last;
  logic             handshake;
  logic             expire;
  logic             in_ready_w;
  logic             out_valid_reg;
  logic [N-1:0]     out_data_reg;
  logic             dup_err_reg;
  logic [CNT_W-1:0] frame_cnt_reg;
  logic             timeout_reg;

  // Sample decode: target bit, merged capture values, frame events.
  always_comb begin
    sel_onehot = {{(N-1){1'b0}}, 1'b1} << bus.in_sel;
    accept     = bus.in_valid && in_ready_w;
    dup        = accept && |(mask_reg & sel_onehot);
    mask_merge = mask_reg | sel_onehot;
    data_merge = bus.in_bit ? (data_reg | sel_onehot) : (data_reg & ~sel_onehot);
    last       = accept && (&mask_merge);
    handshake  = out_valid_reg && bus.out_ready;
  end

`ifdef MUX_STREAM_DEMUX_TIMEOUT_EN
  logic idle;

  // A partial frame is idle when nothing is accepted while collecting.
  always_comb begin
    idle = (state_reg == COLLECT) && (|mask_reg) && !accept;
  end

  mux_stream_idle_timer #(
    .TERM (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (idle),
    .clr    (!idle),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: complete frame moves to HOLD, handoff returns to COLLECT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (last)      state_next = HOLD;
      HOLD:    if (handshake) state_next = COLLECT;
      default:                state_next = COLLECT;
    endcase
  end

  // FSM outputs: samples are only taken while collecting.
  always_comb begin
    in_ready_w = (state_reg == COLLECT);
  end

  // Capture register: merge each accepted sample, clear on completion or expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      mask_reg <= '0;
    end else if (last || expire) begin
      data_reg <= '0;
      mask_reg <= '0;
    end else if (accept) begin
      data_reg <= data_merge;
      mask_reg <= mask_merge;
    end
  end

  // Output word, handoff counter and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      dup_err_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      dup_err_reg <= dup;
      timeout_reg <= expire;
      if (last) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= data_merge;
      end else if (handshake) begin
        out_valid_reg <= 1'b0;
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.dup_err   = dup_err_reg;
  assign bus.frame_cnt = frame_cnt_reg;
  assign bus.timeout   = timeout_reg;

endmodule

// File: doc/mux_stream_demux.md
Name: mux_stream_demux

Overview:
- Receive side of the mux datapath: rebuilds an N-bit word from a stream of (select, bit) samples.
- Each sample is one mux output Y tagged with the select S that produced it.
- Each sample is written into bit position S of a capture register.
- Once every position is filled, the word is presented on a valid/ready output, so a full mux sweep can be checked against the original D word in hardware.

Parameters:
- SEL_W, 2, select width; word width N = 2**SEL_W (localparam, not overridable)
- CNT_W, 8, width of completed-frame counter
- TIMEOUT_CYC, 16, idle cycles before a partial frame is discarded (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample
- in_sel  input  SEL_W  bit position of sample (mux S)
- in_bit  input  1  sample value (mux Y)
- out_valid  output  1  reconstructed word valid
- out_ready  input  1  consumer accepts word
- out_data  output  N  reconstructed word, bit i = sample with sel i
- dup_err  output  1  one-cycle pulse: position written twice in one frame
- frame_cnt  output  CNT_W  count of words handed off, wraps modulo 2**CNT_W
- timeout  output  1  one-cycle pulse: partial frame discarded (tied 0 without the optional feature)

Behaviour:
- Reset (async assert, sync release):
  - State COLLECT; data_q=0, mask_q=0.
  - out_valid=0, out_data=0, dup_err=0, frame_cnt=0, timeout=0.
- COLLECT state:
  - in_ready=1.
  - Accept when in_valid && in_ready: data_q[in_sel]<=in_bit, mask_q[in_sel]<=1.
  - Duplicate: accept with mask_q[in_sel] already 1 overwrites the bit and pulses dup_err next cycle. The frame continues.
  - Completion: the accept that makes mask_q all-ones is the "last accept". On it, out_data<=data_q with the new bit merged, out_valid<=1, mask_q<=0, state->HOLD. out_valid rises the cycle after the last accept (latency 1).
  - Samples may arrive in any select order; only the final value per position counts.
- HOLD state:
  - in_ready=0; out_data is stable while out_valid=1.
  - On out_valid && out_ready: out_valid<=0, frame_cnt<=frame_cnt+1 (wraps), state->COLLECT.
  - Earliest next accept is the cycle after the handshake.
- in_valid with in_ready=0: ignored, nothing captured. The producer must hold the sample.
- Simultaneous duplicate and completion cannot occur: a duplicate never completes the mask.
- Reset mid-frame or mid-HOLD: partial data and any pending word are lost; frame_cnt returns to 0.
- No combinational path from any input to any output except in_ready, which is a function of state only.

Optional Feature:
- Macro: MUX_STREAM_DEMUX_TIMEOUT_EN.
- Defined:
  - Idle counter runs in COLLECT while mask_q!=0 and no accept occurs; it clears on every accept.
  - When it reaches TIMEOUT_CYC: mask_q<=0, data_q<=0, timeout pulses 1 cycle, counter clears.
  - No effect in HOLD or with mask_q==0.
- Undefined: no counter logic; timeout tied 0; partial frames wait indefinitely.

Decomposition:
- Shared package: SEL_W default, state enum (COLLECT, HOLD), and a function computing N from SEL_W.
- Natural sub-module: mux_stream_idle_timer (load-clear counter with terminal pulse). Instantiate it only under the macro.

Test Plan:
- In-order sweep: D=4'b0110 through mux, samples sel 0,1,2,3 with bits 0,1,1,0, out_ready=1 -> out_valid high 1 cycle after the sel=3 accept, out_data=4'b0110, frame_cnt=1.
- Out-of-order: sel 3,1,0,2 with bits 1,0,1,1 -> out_data=4'b1101, dup_err never asserted.
- Duplicate: sel 0(bit 1), 0(bit 0), 1, 2, 3 (bits 1,1,1) -> dup_err pulses once after the second sel=0; out_data=4'b1110.
- Backpressure: out_ready=0 for 5 cycles after completion -> out_valid and out_data hold, in_ready=0, extra in_valid ignored; frame_cnt increments only at the handshake.
- Reset mid-frame: two samples, then rst_n low 1 cycle -> all outputs 0. A following full sweep of 4'b1001 yields out_data=4'b1001, frame_cnt=1.
- Timeout (macro defined, TIMEOUT_CYC=16): sel 0,1 then idle 16 cycles -> timeout pulse, mask cleared. Next full sweep of 4'b0011 yields 4'b0011 with no dup_err.
